// File: rtl/pipeline_hazard_sched.sv
// Hazard scheduler for the 5-stage pipeline: per-register write enables and flushes,
// PC write enable, mul/div EX occupancy sequencing and a saturating stall-cycle counter.
module pipeline_hazard_sched #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             branch,
  input  logic             jump,
  input  logic             ext_stall,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_muldiv,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  output logic [3:0]       pipeline_lock,
  output logic [3:0]       pipeline_clear,
  output logic             pc_write,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MD_CNT_W = $clog2(MD_LATENCY + 1);
  localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LATENCY - 1);
  localparam logic [MD_CNT_W-1:0] MD_LAST   = MD_CNT_W'(1);
  localparam bit MD_MULTI = (MD_LATENCY >= 2);

  // Lock/clear encodings, bit0 = IF/ID .. bit3 = MEM/WB
  localparam logic [3:0] LOCK_ALL  = 4'b1111;
  localparam logic [3:0] LOCK_NONE = 4'b0000;
  localparam logic [3:0] LOCK_MD   = 4'b1100;
  localparam logic [3:0] LOCK_LU   = 4'b1110;
  localparam logic [3:0] CLR_NONE  = 4'b0000;
  localparam logic [3:0] CLR_ALL   = 4'b1111;
  localparam logic [3:0] CLR_MD    = 4'b0100;
  localparam logic [3:0] CLR_BR    = 4'b0011;
  localparam logic [3:0] CLR_LU    = 4'b0010;
  localparam logic [3:0] CLR_JMP   = 4'b0001;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [MD_CNT_W-1:0]   md_cnt_reg, md_cnt_next;
  logic [CNT_W-1:0]      stall_reg, stall_next;

  logic [4:0]            rs_eq_bits, rt_eq_bits;
  logic                  rs_match, rt_match, ex_rt_nonzero, load_use;

  // Bitwise register-number comparison between the load in EX and the ID operands
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_reg_cmp
      assign rs_eq_bits[gi] = ~(ex_rt[gi] ^ id_rs[gi]);
      assign rt_eq_bits[gi] = ~(ex_rt[gi] ^ id_rt[gi]);
    end
  endgenerate

  assign rs_match      = &rs_eq_bits;
  assign rt_match      = &rt_eq_bits;
  assign ex_rt_nonzero = |ex_rt;
  assign load_use      = ex_memread & ex_rt_nonzero & (rs_match | (id_uses_rt & rt_match));

  always_comb begin
    pipeline_lock  = LOCK_ALL;
    pipeline_clear = CLR_NONE;
    pc_write       = 1'b1;
    state_next     = state_reg;
    md_cnt_next    = md_cnt_reg;

    if (reset) begin
      pipeline_clear = CLR_ALL;
      pc_write       = 1'b0;
      state_next     = ST_RUN;
      md_cnt_next    = '0;
    end else if (ext_stall) begin
      // Memory wait freezes everything, including the mul/div countdown
      pipeline_lock  = LOCK_NONE;
      pc_write       = 1'b0;
    end else if (state_reg == ST_MD_BUSY) begin
      pipeline_lock  = LOCK_MD;
      pipeline_clear = CLR_MD;
      pc_write       = 1'b0;
      md_cnt_next    = md_cnt_reg - MD_LAST;
      if (md_cnt_reg == MD_LAST) begin
        state_next = ST_RUN;
      end
    end else if (branch) begin
      // Branch wins over load_use and muldiv: the ID instruction is flushed anyway
      pipeline_clear = CLR_BR;
    end else if (load_use) begin
      pipeline_lock  = LOCK_LU;
      pipeline_clear = CLR_LU;
      pc_write       = 1'b0;
    end else if (jump) begin
      pipeline_clear = CLR_JMP;
    end else if (id_muldiv && MD_MULTI) begin
      state_next     = ST_MD_BUSY;
      md_cnt_next    = MD_RELOAD;
    end
  end

  always_comb begin
    stall_next = stall_reg;
    if (reset) begin
      stall_next = '0;
    end else if (!pc_write && (stall_reg != {CNT_W{1'b1}})) begin
      stall_next = stall_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    state_reg  <= state_next;
    md_cnt_reg <= md_cnt_next;
    stall_reg  <= stall_next;
  end

  assign md_busy      = (state_reg == ST_MD_BUSY) & ~reset;
  assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_pipeline_hazard_sched.sv
// Bench for pipeline_hazard_sched: a cycle-level behavioural model checked every cycle
// against two instances (16-bit and 4-bit counters), plus literal expectations.
module tb_pipeline_hazard_sched;

  localparam int MD_LAT = 4;

  logic        clock = 1'b0;
  logic        reset, branch, jump, ext_stall, id_uses_rt, id_muldiv, ex_memread;
  logic [4:0]  id_rs, id_rt, ex_rt;

  logic [3:0]  lock_a, clear_a, lock_b, clear_b;
  logic        pc_a, busy_a, pc_b, busy_b;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model state: remaining mul/div busy cycles and total stall count
  int md_left = 0;
  int stalls  = 0;

  logic [3:0]  obs_lock, obs_clear;
  logic        obs_pc, obs_busy;
  logic [15:0] obs_stall;
  logic [3:0]  obs_sat;

  pipeline_hazard_sched #(.MD_LATENCY(MD_LAT), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .branch(branch), .jump(jump), .ext_stall(ext_stall),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_muldiv(id_muldiv),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .pipeline_lock(lock_a), .pipeline_clear(clear_a), .pc_write(pc_a), .md_busy(busy_a),
    .stall_cycles(stall_a)
  );

  pipeline_hazard_sched #(.MD_LATENCY(MD_LAT), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .branch(branch), .jump(jump), .ext_stall(ext_stall),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_muldiv(id_muldiv),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .pipeline_lock(lock_b), .pipeline_clear(clear_b), .pc_write(pc_b), .md_busy(busy_b),
    .stall_cycles(stall_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_load_use();
    return ex_memread && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  // Expected combinational outputs for the current model state and inputs
  task automatic model_outputs(output logic [3:0] e_lock, output logic [3:0] e_clear,
                               output logic e_pc, output logic e_busy);
    e_busy = (md_left > 0) && !reset;
    if (reset)               begin e_lock = 4'hF; e_clear = 4'hF; e_pc = 1'b0; end
    else if (ext_stall)      begin e_lock = 4'h0; e_clear = 4'h0; e_pc = 1'b0; end
    else if (md_left > 0)    begin e_lock = 4'hC; e_clear = 4'h4; e_pc = 1'b0; end
    else if (branch)         begin e_lock = 4'hF; e_clear = 4'h3; e_pc = 1'b1; end
    else if (m_load_use())   begin e_lock = 4'hE; e_clear = 4'h2; e_pc = 1'b0; end
    else if (jump)           begin e_lock = 4'hF; e_clear = 4'h1; e_pc = 1'b1; end
    else                     begin e_lock = 4'hF; e_clear = 4'h0; e_pc = 1'b1; end
  endtask

  task automatic model_step(input logic e_pc);
    if (reset) begin
      md_left = 0;
      stalls  = 0;
    end else begin
      if (!e_pc) stalls++;
      if (ext_stall) begin
      end else if (md_left > 0) begin
        md_left--;
      end else if (!branch && !m_load_use() && id_muldiv) begin
        md_left = MD_LAT - 1;
      end
    end
  endtask

  // One clock cycle: compare at negedge, advance the model at posedge
  task automatic tick();
    logic [3:0] e_lock, e_clear;
    logic       e_pc, e_busy;
    @(negedge clock);
    model_outputs(e_lock, e_clear, e_pc, e_busy);
    check("lock",       {28'd0, lock_a},  {28'd0, e_lock});
    check("clear",      {28'd0, clear_a}, {28'd0, e_clear});
    check("pc_write",   {31'd0, pc_a},    {31'd0, e_pc});
    check("md_busy",    {31'd0, busy_a},  {31'd0, e_busy});
    check("stall16",    {16'd0, stall_a}, (stalls > 65535) ? 32'hFFFF : stalls);
    check("lock_sat",   {28'd0, lock_b},  {28'd0, e_lock});
    check("clear_sat",  {28'd0, clear_b}, {28'd0, e_clear});
    check("pc_sat",     {31'd0, pc_b},    {31'd0, e_pc});
    check("busy_sat",   {31'd0, busy_b},  {31'd0, e_busy});
    check("stall4",     {28'd0, stall_b}, (stalls > 15) ? 32'hF : stalls);
    obs_lock = lock_a; obs_clear = clear_a; obs_pc = pc_a; obs_busy = busy_a;
    obs_stall = stall_a; obs_sat = stall_b;
    $display("[TB] cyc %0d rst=%b br=%b jp=%b xs=%b md=%b lu=%b -> lock=%b clear=%b pc=%b busy=%b stalls=%0d/%0d",
             cyc, reset, branch, jump, ext_stall, id_muldiv, m_load_use(),
             lock_a, clear_a, pc_a, busy_a, stall_a, stall_b);
    @(posedge clock);
    model_step(e_pc);
    cyc++;
    #1;
  endtask

  task automatic idle();
    reset = 0; branch = 0; jump = 0; ext_stall = 0; id_uses_rt = 0; id_muldiv = 0;
    ex_memread = 0; id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
  endtask

  task automatic load_use_in();
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    check("rst_lock",  {28'd0, obs_lock},  32'hF);
    check("rst_clear", {28'd0, obs_clear}, 32'hF);
    check("rst_pc",    {31'd0, obs_pc},    32'h0);
    check("rst_busy",  {31'd0, obs_busy},  32'h0);

    idle(); tick();
    check("idle_lock",  {28'd0, obs_lock},  32'hF);
    check("idle_clear", {28'd0, obs_clear}, 32'h0);
    check("idle_pc",    {31'd0, obs_pc},    32'h1);
    check("idle_stall", {16'd0, obs_stall}, 32'd0);

    load_use_in(); tick();
    check("lu_lock",  {28'd0, obs_lock},  32'hE);
    check("lu_clear", {28'd0, obs_clear}, 32'h2);
    check("lu_pc",    {31'd0, obs_pc},    32'h0);
    idle(); tick();
    check("lu_after_pc",    {31'd0, obs_pc},    32'h1);
    check("lu_after_stall", {16'd0, obs_stall}, 32'd1);

    ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0; tick();
    check("r0_no_stall", {31'd0, obs_pc}, 32'h1);

    idle(); ex_memread = 1; ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_uses_rt = 0; tick();
    check("rt_unused_pc", {31'd0, obs_pc}, 32'h1);
    id_uses_rt = 1; tick();
    check("rt_used_clear", {28'd0, obs_clear}, 32'h2);

    idle(); load_use_in(); branch = 1; tick();
    check("br_lu_clear", {28'd0, obs_clear}, 32'h3);
    check("br_lu_pc",    {31'd0, obs_pc},    32'h1);
    idle(); tick();
    check("br_lu_stall", {16'd0, obs_stall}, 32'd2);

    jump = 1; tick();
    check("jump_clear", {28'd0, obs_clear}, 32'h1);

    idle(); id_muldiv = 1; tick();
    check("md_issue_busy", {31'd0, obs_busy}, 32'h0);
    idle(); tick();
    check("md1_lock",  {28'd0, obs_lock},  32'hC);
    check("md1_clear", {28'd0, obs_clear}, 32'h4);
    branch = 1; tick();
    check("md2_br_ignored", {28'd0, obs_clear}, 32'h4);
    idle(); tick();
    check("md3_busy", {31'd0, obs_busy}, 32'h1);
    tick();
    check("md_done_busy",  {31'd0, obs_busy},  32'h0);
    check("md_done_stall", {16'd0, obs_stall}, 32'd5);

    id_muldiv = 1; tick();
    idle(); tick();
    ext_stall = 1; tick();
    check("xs_lock", {28'd0, obs_lock}, 32'h0);
    check("xs_busy", {31'd0, obs_busy}, 32'h1);
    tick();
    idle(); tick(); tick();
    check("xs_md_last_busy", {31'd0, obs_busy}, 32'h1);
    tick();
    check("xs_done_busy",  {31'd0, obs_busy},  32'h0);
    check("xs_done_stall", {16'd0, obs_stall}, 32'd10);

    load_use_in(); id_muldiv = 1; tick();
    check("lu_md_pc", {31'd0, obs_pc}, 32'h0);
    idle(); id_muldiv = 1; tick();
    check("lu_md_issue_busy", {31'd0, obs_busy}, 32'h0);
    idle(); tick();
    check("lu_md_busy", {31'd0, obs_busy}, 32'h1);
    tick(); tick(); tick();
    check("lu_md_stall", {16'd0, obs_stall}, 32'd14);

    id_muldiv = 1; tick();
    idle(); tick();
    reset = 1; tick();
    check("rst_md_clear", {28'd0, obs_clear}, 32'hF);
    check("rst_md_busy",  {31'd0, obs_busy},  32'h0);
    idle(); tick();
    check("post_rst_busy",  {31'd0, obs_busy},  32'h0);
    check("post_rst_lock",  {28'd0, obs_lock},  32'hF);
    check("post_rst_stall", {16'd0, obs_stall}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      load_use_in(); tick();
    end
    idle(); tick();
    check("sat_stall4",  {28'd0, obs_sat},   32'hF);
    check("sat_stall16", {16'd0, obs_stall}, 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
